// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define ADDER_CLA_PIPE_OVF_EN to build the two's-complement overflow flag (otherwise o_ovf is 0).
module adder_cla_pipe #(
    parameter int unsigned BW  = 32,
    parameter int unsigned BLK = 4,
    parameter int unsigned STG = 2
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_vld,
    output logic          o_rdy,
    input  logic [BW-1:0] i_a,
    input  logic [BW-1:0] i_b,
    input  logic          i_c,
    input  logic          i_sub,
    output logic          o_vld,
    input  logic          i_rdy,
    output logic [BW-1:0] o_s,
    output logic          o_c,
    output logic          o_ovf
);
    localparam int unsigned W  = BW / STG;
    localparam int unsigned NB = W / BLK;

    // Carry into every bit of a W-bit slice; index W is the slice carry-out.
    function automatic logic [W:0] cla_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin);
        logic [W-1:0] p;
        logic [W-1:0] g;
        logic [W:0]   c;
        logic         gp;
        logic         gg;
        int unsigned  idx;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int unsigned blk = 0; blk < NB; blk++) begin
            gp = 1'b1;
            gg = 1'b0;
            for (int unsigned i = 0; i < BLK; i++) begin
                idx = blk * BLK + i;
                if (i < BLK - 1) begin
                    c[idx+1] = g[idx] | (p[idx] & c[idx]);
                end
                gg = g[idx] | (p[idx] & gg);
                gp = gp & p[idx];
            end
            c[(blk+1)*BLK] = gg | (gp & c[blk*BLK]);
        end
        return c;
    endfunction

    logic [STG-1:0] vld_q, vld_d;
    logic [STG-1:0] c_q, c_d;
    logic [STG-1:0] en_c;
    logic [BW-1:0]  a_q [STG];
    logic [BW-1:0]  a_d [STG];
    logic [BW-1:0]  b_q [STG];
    logic [BW-1:0]  b_d [STG];
    logic [BW-1:0]  s_q [STG];
    logic [BW-1:0]  s_d [STG];
`ifdef ADDER_CLA_PIPE_OVF_EN
    logic cmsb_q, cmsb_d;
`endif

    // Enable chain from the sink backwards, then each stage adds its slice and passes the rest on.
    always_comb begin : stage_comb
        logic          nxt;
        logic [BW-1:0] cur_a;
        logic [BW-1:0] cur_b;
        logic [BW-1:0] cur_s;
        logic          cur_c;
        logic          cur_v;
        logic [W:0]    cy;
        logic [W-1:0]  sl_s;
        en_c  = '0;
        vld_d = vld_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
`ifdef ADDER_CLA_PIPE_OVF_EN
        cmsb_d = cmsb_q;
`endif
        nxt = i_rdy;
        for (int k = int'(STG) - 1; k >= 0; k--) begin
            en_c[k] = ~vld_q[k] | nxt;
            nxt     = en_c[k];
        end
        cur_a = i_a;
        cur_b = i_b ^ {BW{i_sub}};
        cur_s = '0;
        cur_c = i_c;
        cur_v = i_vld;
        for (int unsigned k = 0; k < STG; k++) begin
            cy   = cla_carries(cur_a[k*W +: W], cur_b[k*W +: W], cur_c);
            sl_s = cur_a[k*W +: W] ^ cur_b[k*W +: W] ^ cy[W-1:0];
            if (en_c[k]) begin
                vld_d[k]          = cur_v;
                a_d[k]            = cur_a;
                b_d[k]            = cur_b;
                s_d[k]            = cur_s;
                s_d[k][k*W +: W]  = sl_s;
                c_d[k]            = cy[W];
`ifdef ADDER_CLA_PIPE_OVF_EN
                if (k == STG - 1) begin
                    cmsb_d = cy[W-1];
                end
`endif
            end
            cur_a = a_q[k];
            cur_b = b_q[k];
            cur_s = s_q[k];
            cur_c = c_q[k];
            cur_v = vld_q[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int unsigned k = 0; k < STG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            for (int unsigned k = 0; k < STG; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

`ifdef ADDER_CLA_PIPE_OVF_EN
    // Carry into the MSB, kept alongside the final carry-out.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cmsb_q <= 1'b0;
        end else begin
            cmsb_q <= cmsb_d;
        end
    end
    assign o_ovf = cmsb_q ^ c_q[STG-1];
`else
    assign o_ovf = 1'b0;
`endif

    assign o_rdy = en_c[0];
    assign o_vld = vld_q[STG-1];
    assign o_s   = s_q[STG-1];
    assign o_c   = c_q[STG-1];

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Directed self-checking bench for adder_cla_pipe: default 32/4/2 instance plus a parameter sweep.
module tb_adder_cla_pipe;
`ifdef ADDER_CLA_PIPE_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, i_vld, i_c, i_sub, i_rdy;
    logic [31:0] i_a, i_b;
    logic        o_rdy, o_vld, o_c, o_ovf;
    logic [31:0] o_s;

    logic        sw_vld, sw_c;
    logic [63:0] sw_a, sw_b;
    logic        r8, v8, c8, ov8;
    logic [7:0]  s8;
    logic        r44, v44, c44, ov44;
    logic [63:0] s44;
    logic        r82, v82, c82, ov82;
    logic [63:0] s82;

    int total = 0;
    int bad   = 0;

    adder_cla_pipe #(.BW(32), .BLK(4), .STG(2)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_vld(i_vld), .o_rdy(o_rdy), .i_a(i_a), .i_b(i_b),
        .i_c(i_c), .i_sub(i_sub), .o_vld(o_vld), .i_rdy(i_rdy), .o_s(o_s), .o_c(o_c), .o_ovf(o_ovf));

    adder_cla_pipe #(.BW(8), .BLK(4), .STG(1)) u_sw8 (
        .i_clk(clk), .i_rstn(rstn), .i_vld(sw_vld), .o_rdy(r8), .i_a(sw_a[7:0]), .i_b(sw_b[7:0]),
        .i_c(sw_c), .i_sub(1'b0), .o_vld(v8), .i_rdy(1'b1), .o_s(s8), .o_c(c8), .o_ovf(ov8));

    adder_cla_pipe #(.BW(64), .BLK(4), .STG(4)) u_sw44 (
        .i_clk(clk), .i_rstn(rstn), .i_vld(sw_vld), .o_rdy(r44), .i_a(sw_a), .i_b(sw_b),
        .i_c(sw_c), .i_sub(1'b0), .o_vld(v44), .i_rdy(1'b1), .o_s(s44), .o_c(c44), .o_ovf(ov44));

    adder_cla_pipe #(.BW(64), .BLK(8), .STG(2)) u_sw82 (
        .i_clk(clk), .i_rstn(rstn), .i_vld(sw_vld), .o_rdy(r82), .i_a(sw_a), .i_b(sw_b),
        .i_c(sw_c), .i_sub(1'b0), .o_vld(v82), .i_rdy(1'b1), .o_s(s82), .o_c(c82), .o_ovf(ov82));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // 33-bit reference with signed-overflow rule; packed as {ovf, carry, sum}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic sub);
        logic [31:0] bb;
        logic [32:0] sum;
        logic        ovf;
        bb  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + 33'(c);
        ovf = OVF && (a[31] == bb[31]) && (sum[31] != a[31]);
        return {ovf, sum};
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic sub, input logic rdy, input logic rn);
        @(posedge clk);
        #1;
        i_vld = v; i_a = a; i_b = b; i_c = c; i_sub = sub; i_rdy = rdy; rstn = rn;
        @(negedge clk);
    endtask

    // Scoreboard: push on accept, pop and compare on emit.
    logic [33:0] q[$];
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
        end else begin
            if (o_vld && i_rdy) begin
                if (q.size() == 0) begin
                    check("spurious_result", 128'(o_vld), 128'(1'b0));
                end else begin
                    check("stream_result", 128'({o_ovf, o_c, o_s}), 128'(q.pop_front()));
                end
            end
            if (i_vld && o_rdy) q.push_back(model(i_a, i_b, i_c, i_sub));
        end
    end

    task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic sub, input logic [31:0] es, input logic ec, input logic eo);
        step(1'b1, a, b, c, sub, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check({tag, "_early_vld"}, 128'(o_vld), 128'(1'b0));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check({tag, "_vld"}, 128'(o_vld), 128'(1'b1));
        check({tag, "_s"},   128'(o_s),   128'(es));
        check({tag, "_c"},   128'(o_c),   128'(ec));
        check({tag, "_ovf"}, 128'(o_ovf), 128'(eo));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic sweep_case(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic c);
        bit       g8, g44, g82;
        int       l8, l44, l82;
        logic [8:0]  cs8;
        logic [64:0] cs44, cs82;
        g8 = 0; g44 = 0; g82 = 0; l8 = 99; l44 = 99; l82 = 99;
        cs8 = '0; cs44 = '0; cs82 = '0;
        @(posedge clk);
        #1;
        sw_vld = 1'b1; sw_a = a; sw_b = b; sw_c = c;
        @(negedge clk);
        check({tag, "_rdy"}, 128'({r8, r44, r82}), 128'(3'b111));
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            sw_vld = 1'b0;
            @(negedge clk);
            if (v8 && !g8)   begin g8 = 1;  l8 = i;  cs8 = {c8, s8};    end
            if (v44 && !g44) begin g44 = 1; l44 = i; cs44 = {c44, s44}; end
            if (v82 && !g82) begin g82 = 1; l82 = i; cs82 = {c82, s82}; end
        end
        check({tag, "_lat_8_4_1"},  128'(l8),  128'(1));
        check({tag, "_lat_64_4_4"}, 128'(l44), 128'(4));
        check({tag, "_lat_64_8_2"}, 128'(l82), 128'(2));
        check({tag, "_cs_8_4_1"},   128'(cs8),  128'({1'b1, 8'h00}));
        check({tag, "_cs_64_4_4"},  128'(cs44), 128'({1'b1, 64'h0}));
        check({tag, "_cs_64_8_2"},  128'(cs82), 128'({1'b1, 64'h0}));
        check({tag, "_ovf"}, 128'({ov8, ov44, ov82}), 128'(3'b000));
    endtask

    initial begin
        logic [11:0] pat;
        logic [31:0] a_bp [3];
        logic [31:0] b_bp [3];
        logic        c_bp [3];
        logic        sub_bp [3];
        int          idx;
        int          outs;

        rstn = 1'b0; i_vld = 1'b0; i_a = '0; i_b = '0; i_c = 1'b0; i_sub = 1'b0; i_rdy = 1'b1;
        sw_vld = 1'b0; sw_a = '0; sw_b = '0; sw_c = 1'b0;

        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_vld", 128'(o_vld), 128'(1'b0));
        check("reset_rdy", 128'(o_rdy), 128'(1'b1));
        check("reset_s",   128'(o_s),   128'(32'h0));
        check("reset_c",   128'(o_c),   128'(1'b0));
        check("reset_ovf", 128'(o_ovf), 128'(1'b0));

        dir("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        dir("sub_5_7",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF);
        dir("ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, OVF);

        pat = '0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 1'b1, 1'b1);
            else       step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
            pat[i] = o_vld;
        end
        check("stream_vld_pattern", 128'(pat), 128'(12'b0011_1111_1100));

        a_bp[0] = 32'h1234_5678; b_bp[0] = 32'h1111_1111; c_bp[0] = 1'b0; sub_bp[0] = 1'b0;
        a_bp[1] = 32'hFFFF_0000; b_bp[1] = 32'h0001_0000; c_bp[1] = 1'b0; sub_bp[1] = 1'b0;
        a_bp[2] = 32'h0000_000A; b_bp[2] = 32'h0000_0003; c_bp[2] = 1'b1; sub_bp[2] = 1'b1;
        idx = 0;
        for (int t = 0; t < 5; t++) begin
            step(1'b1, a_bp[idx], b_bp[idx], c_bp[idx], sub_bp[idx], 1'b0, 1'b1);
            check("bp_rdy", 128'(o_rdy), 128'(t < 2));
            check("bp_vld", 128'(o_vld), 128'(t >= 2));
            if (t >= 2) check("bp_hold_s", 128'({o_c, o_s}), 128'({1'b0, 32'h2345_6789}));
            if (o_rdy) idx++;
        end
        outs = 0;
        for (int t = 0; t < 8; t++) begin
            if (idx < 3) step(1'b1, a_bp[idx], b_bp[idx], c_bp[idx], sub_bp[idx], 1'b1, 1'b1);
            else         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (o_vld) outs++;
            if (o_rdy && idx < 3) idx++;
        end
        check("bp_out_count", 128'(outs), 128'(3));

        step(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_mid_vld", 128'(o_vld), 128'(1'b0));
        check("rst_mid_sc",  128'({o_ovf, o_c, o_s}), 128'(34'h0));
        check("rst_mid_rdy", 128'(o_rdy), 128'(1'b1));
        for (int t = 0; t < 4; t++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
            check("rst_no_stale", 128'(o_vld), 128'(1'b0));
        end

        sweep_case("sw_ones_p1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        sweep_case("sw_55_aa",   64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);

        check("drained", 128'(q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
